// File: rtl/spi_flash_emu.sv
// SPI NOR flash emulator (mode 0), oversampled on clk: READ 03h, FAST_READ 0Bh, RDID 9Fh.
// Define SPI_FLASH_EMU_PROGRAM_EN to add WREN 06h, WRDI 04h, RDSR 05h and PP 02h.
`timescale 1ns/1ps
module spi_flash_emu #(
  parameter int unsigned DEPTH        = 65536,
  parameter int unsigned DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'hef4016
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic csn,
  input  logic mosi,
  output logic miso,
  output logic miso_oe
);

  localparam int AW = $clog2(DEPTH);
`ifdef SPI_FLASH_EMU_PROGRAM_EN
  localparam bit PGM_EN = 1'b1;
`else
  localparam bit PGM_EN = 1'b0;
`endif
  localparam logic [AW-1:0] PAGE_MASK  = AW'(255);
  localparam logic [4:0]    DUMMY_LAST = (DUMMY_CYCLES == 0) ? 5'd0 : 5'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {CMD, ADDR, DUMMY, DOUT, DIN, NOP} state_t;
  typedef enum logic [1:0] {SRC_MEM, SRC_ID, SRC_STATUS} src_t;

  logic          r_sck_s1, r_sck_s2, r_sck_d;
  logic          r_csn_s1, r_csn_s2;
  logic          r_mosi_s1, r_mosi_s2;
  state_t        r_state;
  src_t          r_src;
  logic [7:0]    r_cmd;
  logic [4:0]    r_bit_cnt;
  logic [6:0]    r_sr;
  logic [6:0]    r_out_sr;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_id_idx;
  logic          r_wel;
  logic          r_pgm;
  logic          r_miso;
  logic          r_miso_oe;
  logic [7:0]    r_rd_data;
  logic [7:0]    r_mem [DEPTH];

  logic          w_sck_rise;
  logic          w_sck_fall;
  logic [7:0]    w_in_byte;
  logic [7:0]    w_out_byte;
  logic          w_mem_we;
  logic [7:0]    w_mem_wdata;

  assign w_sck_rise = r_sck_s2 & ~r_sck_d;
  assign w_sck_fall = ~r_sck_s2 & r_sck_d;
  assign w_in_byte  = {r_sr, r_mosi_s2};
  assign miso       = r_miso;
  assign miso_oe    = r_miso_oe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_d   <= 1'b0;
      r_csn_s1  <= 1'b1;
      r_csn_s2  <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_d   <= r_sck_s2;
      r_csn_s1  <= csn;
      r_csn_s2  <= r_csn_s1;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // Byte presented at the start of each output byte; r_rd_data always tracks r_mem[r_addr].
  always_comb begin
    w_out_byte = 8'hFF;
    case (r_src)
      SRC_MEM: w_out_byte = r_rd_data;
      SRC_ID: begin
        case (r_id_idx)
          2'd0:    w_out_byte = JEDEC_ID[23:16];
          2'd1:    w_out_byte = JEDEC_ID[15:8];
          2'd2:    w_out_byte = JEDEC_ID[7:0];
          default: w_out_byte = 8'hFF;
        endcase
      end
      SRC_STATUS: w_out_byte = {6'h00, r_wel, 1'b0};
      default: w_out_byte = 8'hFF;
    endcase
  end

  always_comb begin
    w_mem_we    = PGM_EN && !r_csn_s2 && w_sck_rise && (r_state == DIN) && (r_bit_cnt == 5'd7);
    w_mem_wdata = r_rd_data & w_in_byte;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= w_mem_wdata;
    end
    r_rd_data <= r_mem[r_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CMD;
      r_src     <= SRC_MEM;
      r_cmd     <= 8'h00;
      r_bit_cnt <= 5'd0;
      r_sr      <= 7'h00;
      r_out_sr  <= 7'h7F;
      r_addr    <= '0;
      r_id_idx  <= 2'd0;
      r_wel     <= 1'b0;
      r_pgm     <= 1'b0;
      r_miso    <= 1'b1;
      r_miso_oe <= 1'b0;
    end else if (r_csn_s2) begin
      // Deselect wins over any sck edge seen in the same cycle.
      r_state   <= CMD;
      r_bit_cnt <= 5'd0;
      r_miso    <= 1'b1;
      r_miso_oe <= 1'b0;
      if (r_pgm) begin
        r_wel <= 1'b0;
        r_pgm <= 1'b0;
      end
    end else if (w_sck_rise) begin
      case (r_state)
        CMD: begin
          r_sr <= w_in_byte[6:0];
          if (r_bit_cnt == 5'd7) begin
            r_bit_cnt <= 5'd0;
            case (w_in_byte)
              8'h03, 8'h0B: begin
                r_state <= ADDR;
                r_cmd   <= w_in_byte;
              end
              8'h9F: begin
                r_state  <= DOUT;
                r_src    <= SRC_ID;
                r_id_idx <= 2'd0;
              end
              8'h06: begin
                r_state <= NOP;
                if (PGM_EN) r_wel <= 1'b1;
              end
              8'h04: begin
                r_state <= NOP;
                r_wel   <= 1'b0;
              end
              8'h05: begin
                r_src <= SRC_STATUS;
                if (PGM_EN) r_state <= DOUT;
                else        r_state <= NOP;
              end
              8'h02: begin
                if (PGM_EN && r_wel) begin
                  r_state <= ADDR;
                  r_cmd   <= w_in_byte;
                  r_pgm   <= 1'b1;
                end else begin
                  r_state <= NOP;
                end
              end
              default: r_state <= NOP;
            endcase
          end else begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        ADDR: begin
          // Shifting through an AW-bit register keeps only the address modulo DEPTH.
          r_addr <= {r_addr[AW-2:0], r_mosi_s2};
          if (r_bit_cnt == 5'd23) begin
            r_bit_cnt <= 5'd0;
            r_src     <= SRC_MEM;
            case (r_cmd)
              8'h0B: begin
                if (DUMMY_CYCLES == 0) r_state <= DOUT;
                else                   r_state <= DUMMY;
              end
              8'h02:   r_state <= DIN;
              default: r_state <= DOUT;
            endcase
          end else begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        DUMMY: begin
          if (r_bit_cnt == DUMMY_LAST) begin
            r_bit_cnt <= 5'd0;
            r_state   <= DOUT;
          end else begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        DIN: begin
          r_sr <= w_in_byte[6:0];
          if (r_bit_cnt == 5'd7) begin
            r_bit_cnt <= 5'd0;
            r_addr    <= (r_addr & ~PAGE_MASK) | ((r_addr + 1'b1) & PAGE_MASK);
          end else begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end else if (w_sck_fall && (r_state == DOUT)) begin
      if (r_bit_cnt[2:0] == 3'd0) begin
        r_miso    <= w_out_byte[7];
        r_out_sr  <= w_out_byte[6:0];
        r_miso_oe <= 1'b1;
        if (r_src == SRC_MEM) r_addr <= r_addr + 1'b1;
        if ((r_src == SRC_ID) && (r_id_idx != 2'd3)) r_id_idx <= r_id_idx + 2'd1;
      end else begin
        r_miso   <= r_out_sr[6];
        r_out_sr <= {r_out_sr[5:0], 1'b1};
      end
      r_bit_cnt <= {2'b00, r_bit_cnt[2:0] + 3'd1};
    end
  end

endmodule

// File: doc/spi_flash_emu.md
SPI_FLASH_EMU -- requirements
Module: spi_flash_emu

Interface
REQ-001 SHALL have parameter DEPTH, default 65536, memory size in bytes; power of two, 256 to 16777216.
REQ-002 SHALL have parameter DUMMY_CYCLES, default 8, SCK cycles between address and data for command 0Bh; range 0 to 15.
REQ-003 SHALL have parameter JEDEC_ID, default 24'hef4016, 24-bit ID returned by 9Fh, MSB first.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port sck  input  1  SPI clock, asynchronous to clk, mode 0 only.
REQ-007 SHALL have port csn  input  1  chip select, active-low, asynchronous to clk.
REQ-008 SHALL have port mosi  input  1  serial data in (IO0).
REQ-009 SHALL have port miso  output  1  serial data out (IO1).
REQ-010 SHALL have port miso_oe  output  1  output enable for miso; the bench tristates IO1 when low.

Function
REQ-011 SHALL pass sck, csn and mosi each through a 2-flop synchroniser on clk, then detect sck rise and fall edges from the synchronised value; correct operation requires f_clk >= 8 x f_sck.
REQ-012 SHALL sample mosi on each synchronised sck rise and update miso on each synchronised sck fall, MSB first.
REQ-013 SHALL update miso no later than 3 clk cycles after the sck pin falls.
REQ-014 SHALL have states CMD, ADDR, DUMMY, DOUT, DIN and NOP.
REQ-015 SHALL shift 8 bits in CMD, then decode: 03h -> ADDR; 0Bh -> ADDR; 9Fh -> DOUT (ID source); any other opcode -> NOP.
REQ-016 SHALL shift 24 address bits in ADDR, taking the address modulo DEPTH.
REQ-017 After ADDR, 03h SHALL enter DOUT; 0Bh SHALL enter DUMMY for DUMMY_CYCLES rises, or go directly to DOUT when DUMMY_CYCLES = 0.
REQ-018 SHALL drive bit 7 of the first byte on the sck fall that follows the final address or dummy rise.
REQ-019 SHALL increment the address after each 8th output bit in DOUT, wrapping from DEPTH-1 to 0, so reads continue indefinitely.
REQ-020 SHALL, for 9Fh, output the three JEDEC_ID bytes, then all-ones bytes.
REQ-021 SHALL assert miso_oe only in DOUT, from the first data-bit fall until csn deasserts; otherwise miso = 1 and miso_oe = 0.
REQ-022 SHALL ignore sck edges in NOP until csn deasserts.
REQ-023 SHALL, on synchronised csn high at any point, including mid-byte, return to CMD, clear the bit counter, set miso = 1 and miso_oe = 0 in the same cycle, and discard any partial byte.
REQ-024 SHALL ignore sck edges while synchronised csn is high.
REQ-025 SHALL, when sck and csn transitions are synchronised in the same clk cycle, give the csn rise priority.

Reset
REQ-026 SHALL, on rst, set state = CMD, bit counter = 0, address = 0, miso = 1, miso_oe = 0, synchronisers to sck = 0, csn = 1, mosi = 0, and WEL = 0.
REQ-027 SHALL leave memory contents unchanged on rst; initial contents come from bench preload, not from reset.

Configuration
REQ-028 SHALL, with SPI_FLASH_EMU_PROGRAM_EN defined, implement the write commands in REQ-029 to REQ-032.
REQ-029 06h SHALL set WEL; 04h SHALL clear WEL.
REQ-030 05h SHALL enter DOUT and repeat the status byte {6'h0, WEL, 1'b0} until csn rises.
REQ-031 02h SHALL run ADDR then DIN; each complete input byte ANDs into mem[addr], with the address incrementing within the 256-byte page (bits [7:0] wrap, upper bits held).
REQ-032 02h SHALL, on csn rise, clear WEL; if WEL = 0 at opcode decode, 02h SHALL go to NOP and leave memory unchanged.
REQ-033 SHALL, without SPI_FLASH_EMU_PROGRAM_EN, decode 06h/04h/05h/02h as NOP, hold WEL at 0 and never write memory.

Verification
REQ-034 V1: preload mem[0x10..0x13] = 11 22 33 44; send 03 00 00 10 and clock 32 bits -> miso returns 11 22 33 44, miso_oe high only during data.
REQ-035 V2: DEPTH = 65536, mem[0xffff] = A5, mem[0] = 5A; send 03 00 FF FF and clock 16 bits -> A5 5A (wrap).
REQ-036 V3: send 0B 00 00 10 + 8 dummy cycles -> 11 first; send 9F -> EF 40 16 FF.
REQ-037 V4: raise csn after 4 bits of the second address byte, then send 03 00 00 11 -> 22; an unknown opcode (ABh) -> miso_oe low throughout.
REQ-038 V5 (PROGRAM_EN): 06; 02 00 01 FE + byte 0F with mem[0x1FE] = FF -> mem[0x1FE] = 0F; then 05 -> 00; 02 without 06 -> memory unchanged.
REQ-039 V6: assert rst mid-DOUT -> miso = 1 and miso_oe = 0 immediately, next command decodes normally.
